coupler_4to8: RTL
=================

// Module: coupler_4to8
// PURPOSE
//  Width coupler directly upstream of the 8-wide merger. Pairs consecutive 4-tuple words
//  from a 4-wide merger's output FIFO into 8-tuple words for the 8-wide merger's input FIFO.
//  Runs end with a terminator word (lowest tuple == 0); each one becomes an all-zero 8-tuple word.
//  Output handshake matches the merger: registered ready, internal 4-entry output queue.
// PARAMETERS
//  DATA_WIDTH  128  bits per tuple
//  KEY_WIDTH   80   key bits per tuple (carried through, not compared)
//  CNT_WIDTH   32   width of the terminator counter o_runs
// PORTS
//  i_clk             in   1             clock, all logic on posedge
//  i_rst             in   1             synchronous reset, active-high
//  i_fifo            in   4*DATA_WIDTH  head word of upstream FIFO; tuple 0 in [DATA_WIDTH-1:0]
//  i_fifo_empty      in   1             upstream FIFO empty
//  o_fifo_read       out  1             pop upstream head; i_fifo is consumed in this same cycle
//  i_fifo_out_ready  in   1             downstream FIFO can accept (registered internally)
//  o_out_fifo_write  out  1             o_data valid, write downstream this cycle
//  o_data            out  8*DATA_WIDTH  queue head word
//  o_err             out  1             sticky: terminator arrived with half-word pending
//  o_runs            out  CNT_WIDTH     number of terminators emitted, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset values: o_fifo_read=0, o_out_fifo_write=0, o_data=0, o_err=0, o_runs=0.
//   Reset also clears ready_q, the pending half and the queue (count=0).
//  Reset mid-operation: the pending half and queued words are discarded without being written.
//   o_fifo_read is forced to 0 while i_rst=1.
//  ready_q <= i_fifo_out_ready each cycle.
//  Output: o_out_fifo_write = ready_q & (count!=0); o_data = queue head; head pops on write.
//  Input: o_fifo_read = ~i_rst & ~i_fifo_empty & (count<=3), using count at cycle start.
//   The queue never overflows because at most 1 word enters per cycle.
//  State: pend_v (1b), pend (4*DATA_WIDTH). Per accepted word w (o_fifo_read=1):
//   - w[DATA_WIDTH-1:0]!=0, pend_v=0: pend<=w, pend_v<=1; no enqueue.
//   - w nonzero, pend_v=1: enqueue {w, pend} (pend in low half), pend_v<=0.
//   - w terminator, pend_v=0: enqueue all-zero word; o_runs<=o_runs+1.
//   - w terminator, pend_v=1: enqueue all-zero word; drop pend; pend_v<=0; o_err<=1; o_runs+1.
//  Terminator test is lowest tuple == 0 only; upper tuples of w are ignored.
//  Latency: completing word accepted at cycle t -> enqueued at edge t;
//   o_out_fifo_write no earlier than t+1, given ready_q=1 at t+1.
//  Simultaneous enqueue and dequeue: count unchanged, order preserved (FIFO).
//  count==4 with dequeue in the same cycle: no read that cycle (conservative); read resumes next cycle.
//  ready drop: i_fifo_out_ready low at t -> no write at t+1; at most 1 write after deassert.
//  Throughput: 1 output word per 2 input words sustained; pure terminators 1:1.
//  No combinational path from i_fifo_out_ready to any output; i_fifo_empty -> o_fifo_read only.
// TESTING
//  1 Reset, ready=1, feed words A,B (nonzero) -> one write, o_data={B,A}, o_err=0, o_runs=0.
//  2 Feed A,B,C,D,Z (Z low tuple 0) -> writes {B,A},{D,C},0; o_runs=1; o_err=0.
//  3 Feed A,Z -> single write of all-zero word; A dropped; o_err=1 stays until reset.
//  4 ready=0, stream 10 nonzero words -> exactly 4 enqueued, o_fifo_read low; pend_v=1 after the 9th.
//    Raise ready -> the 4 words drain in order, then the stream resumes.
//  5 Toggle ready each cycle, feed 64 words and 8 terminators -> output matches model; nothing lost or duplicated.
//  6 Assert i_rst with count=3 and pend_v=1 -> next cycle no writes, o_runs=0, o_err=0.
//    Then A,B -> {B,A}.

Source files
------------

// File: rtl/coupler_4to8.sv
// Width coupler: pairs consecutive 4-tuple words into 8-tuple words ahead of the 8-wide merger.
// A terminator word (lowest tuple zero) becomes an all-zero 8-tuple word and bumps o_runs.
module coupler_4to8 #(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 80,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*DATA_WIDTH-1:0] i_fifo,
    input  logic                    i_fifo_empty,
    output logic                    o_fifo_read,
    input  logic                    i_fifo_out_ready,
    output logic                    o_out_fifo_write,
    output logic [8*DATA_WIDTH-1:0] o_data,
    output logic                    o_err,
    output logic [CNT_WIDTH-1:0]    o_runs
);

    localparam int IN_W  = 4 * DATA_WIDTH;
    localparam int OUT_W = 8 * DATA_WIDTH;

    // Handshake: a word moves downstream on every cycle where o_out_fifo_write=1 (no
    // back-pressure inside that cycle); ready is the registered copy of i_fifo_out_ready.
    // Upstream, o_fifo_read=1 pops the head and i_fifo is taken in that same cycle.

    logic                 ready_q;
    logic                 pend_v_q, pend_v_d;
    logic [IN_W-1:0]      pend_q, pend_d;
    logic [OUT_W-1:0]     q_mem [4];
    logic [1:0]           wr_ptr_q, wr_ptr_d;
    logic [1:0]           rd_ptr_q, rd_ptr_d;
    logic [2:0]           count_q, count_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] runs_q, runs_d;

    logic                 rd;
    logic                 deq;
    logic                 enq;
    logic [OUT_W-1:0]     enq_data;
    logic                 is_term;

    // Terminator test covers the whole lowest tuple: key field and payload both zero.
    assign is_term = (i_fifo[KEY_WIDTH-1:0] == '0) &&
                     (i_fifo[DATA_WIDTH-1:KEY_WIDTH] == '0);

    always_comb begin
        rd       = ~i_rst & ~i_fifo_empty & (count_q <= 3'd3);
        deq      = ready_q & (count_q != 3'd0);
        enq      = 1'b0;
        enq_data = '0;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        err_d    = err_q;
        runs_d   = runs_q;
        if (rd) begin
            if (!is_term) begin
                if (!pend_v_q) begin
                    pend_d   = i_fifo;
                    pend_v_d = 1'b1;
                end else begin
                    enq      = 1'b1;
                    enq_data = {i_fifo, pend_q};
                    pend_v_d = 1'b0;
                end
            end else begin
                enq      = 1'b1;
                enq_data = '0;
                pend_v_d = 1'b0;
                runs_d   = runs_q + 1'b1;
                if (pend_v_q) begin
                    err_d = 1'b1;
                end
            end
        end
        wr_ptr_d = enq ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q + {2'b00, enq} - {2'b00, deq};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ready_q  <= 1'b0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            err_q    <= 1'b0;
            runs_q   <= '0;
        end else begin
            ready_q  <= i_fifo_out_ready;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            runs_q   <= runs_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        if (enq) begin
            q_mem[wr_ptr_q] <= enq_data;
        end
    end

    assign o_fifo_read      = rd;
    assign o_out_fifo_write = deq;
    assign o_data           = (count_q != 3'd0) ? q_mem[rd_ptr_q] : '0;
    assign o_err            = err_q;
    assign o_runs           = runs_q;

endmodule
